// File: rtl/regdst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regdst_pkg
// Brief    : Shared encodings, stage-entry control type and sizing helper for
//            the pipelined register-destination tracker.
// Revision : 1.0
// ============================================================================
package regdst_pkg;

    localparam logic [1:0] REGDST_RT   = 2'b00;
    localparam logic [1:0] REGDST_RD   = 2'b01;
    localparam logic [1:0] REGDST_LINK = 2'b10;
    localparam logic [1:0] REGDST_RSVD = 2'b11;

    localparam int REG_ZERO = 0;

    // Control half of a stage entry; the address half is width-parametrised
    // and joined to this in the top level.
    typedef struct packed {
        logic we;
        logic load;
    } stage_ctl_t;

    function automatic int sel_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regdst_match.sv
`default_nettype none
// ============================================================================
// Module   : regdst_match
// Brief    : Priority comparator returning the youngest in-flight stage whose
//            write destination equals the query address.
// Revision : 1.0
// ============================================================================
module regdst_match
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = 2
)(
    input  logic [DEPTH*ADDR_W-1:0] i_stage_addr,
    input  logic [DEPTH-1:0]        i_stage_we,
    input  logic [ADDR_W-1:0]       i_query,
    output logic                    o_hit,
    output logic [SEL_W-1:0]        o_stage
);

    // Scanning oldest to youngest lets the youngest match overwrite the rest.
    always_comb begin
        o_hit   = 1'b0;
        o_stage = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (i_stage_we[k] && (i_query != '0) &&
                (i_stage_addr[k*ADDR_W +: ADDR_W] == i_query)) begin
                o_hit   = 1'b1;
                o_stage = SEL_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regdst_pipe.sv
`default_nettype none
// ============================================================================
// Module   : regdst_pipe
// Brief    : Register-destination select, DEPTH-stage destination pipeline
//            (EX..WB) and decode-stage forwarding / load-use detection.
// Revision : 1.0
// ============================================================================
module regdst_pipe
    import regdst_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int LINK_REG = 31,
    parameter int SEL_W    = sel_width(DEPTH)
)(
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [ADDR_W-1:0]       rt,
    input  logic [ADDR_W-1:0]       rd,
    input  logic [1:0]              reg_dst,
    input  logic                    reg_write_in,
    input  logic                    mem_read_in,
    input  logic                    hold,
    input  logic                    bubble,
    input  logic [ADDR_W-1:0]       rs_q,
    input  logic [ADDR_W-1:0]       rt_q,
    output logic [DEPTH*ADDR_W-1:0] stage_addr,
    output logic [DEPTH-1:0]        stage_we,
    output logic [ADDR_W-1:0]       wb_addr,
    output logic                    wb_we,
    output logic                    fwd_rs_hit,
    output logic [SEL_W-1:0]        fwd_rs_stage,
    output logic                    fwd_rt_hit,
    output logic [SEL_W-1:0]        fwd_rt_stage,
    output logic                    load_use
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        stage_ctl_t        ctl;
    } stage_entry_t;

    if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
        $error("regdst_pipe: DEPTH must lie in 2..8");
    end
    if (SEL_W != sel_width(DEPTH)) begin : g_bad_sel_w
        $error("regdst_pipe: SEL_W must not be overridden");
    end

    stage_entry_t      r_stage [DEPTH];
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_sel_we;
    logic              w_sel_load;
    stage_entry_t      w_next0;

    always_comb begin
        case (reg_dst)
            REGDST_RT:   w_sel_addr = rt;
            REGDST_RD:   w_sel_addr = rd;
            REGDST_LINK: w_sel_addr = ADDR_W'(LINK_REG);
            default:     w_sel_addr = '0;
        endcase
    end

    // Writes to $zero are architecturally void, so they never travel as writes.
    assign w_sel_we   = reg_write_in && (reg_dst != REGDST_RSVD) &&
                        (w_sel_addr != ADDR_W'(REG_ZERO));
    assign w_sel_load = mem_read_in && w_sel_we;

    // A reserved select is indistinguishable from an explicit bubble.
    always_comb begin
        w_next0 = '0;
        if (!bubble && (reg_dst != REGDST_RSVD)) begin
            w_next0.addr     = w_sel_addr;
            w_next0.ctl.we   = w_sel_we;
            w_next0.ctl.load = w_sel_load;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= '0;
            end
        end else if (!hold) begin
            r_stage[0] <= w_next0;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_out
        assign stage_addr[k*ADDR_W +: ADDR_W] = r_stage[k].addr;
        assign stage_we[k]                    = r_stage[k].ctl.we;
    end

    assign wb_addr = r_stage[DEPTH-1].addr;
    assign wb_we   = r_stage[DEPTH-1].ctl.we;

    regdst_match #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .SEL_W  (SEL_W)
    ) u_match_rs (
        .i_stage_addr (stage_addr),
        .i_stage_we   (stage_we),
        .i_query      (rs_q),
        .o_hit        (fwd_rs_hit),
        .o_stage      (fwd_rs_stage)
    );

    regdst_match #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .SEL_W  (SEL_W)
    ) u_match_rt (
        .i_stage_addr (stage_addr),
        .i_stage_we   (stage_we),
        .i_query      (rt_q),
        .o_hit        (fwd_rt_hit),
        .o_stage      (fwd_rt_stage)
    );

    // Only an EX-stage load is too late to forward; later loads have data.
    assign load_use = r_stage[0].ctl.load &&
                      (r_stage[0].addr != ADDR_W'(REG_ZERO)) &&
                      ((r_stage[0].addr == rs_q) || (r_stage[0].addr == rt_q));

endmodule
`default_nettype wire

// File: tb/tb_regdst_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_regdst_pipe
// Brief    : Self-checking bench for regdst_pipe (directed + random traffic
//            against a behavioural history model).
// Revision : 1.0
// ============================================================================
module tb_regdst_pipe;

    localparam int ADDR_W   = 5;
    localparam int DEPTH    = 3;
    localparam int SEL_W    = 2;
    localparam int LINK_REG = 31;

    logic                    clock = 1'b0;
    logic                    reset_n;
    logic [ADDR_W-1:0]       rt, rd, rs_q, rt_q;
    logic [1:0]              reg_dst;
    logic                    reg_write_in, mem_read_in, hold, bubble;
    logic [DEPTH*ADDR_W-1:0] stage_addr;
    logic [DEPTH-1:0]        stage_we;
    logic [ADDR_W-1:0]       wb_addr;
    logic                    wb_we, fwd_rs_hit, fwd_rt_hit, load_use;
    logic [SEL_W-1:0]        fwd_rs_stage, fwd_rt_stage;

    always #5 clock = ~clock;

    regdst_pipe #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .LINK_REG (LINK_REG)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .rt           (rt),
        .rd           (rd),
        .reg_dst      (reg_dst),
        .reg_write_in (reg_write_in),
        .mem_read_in  (mem_read_in),
        .hold         (hold),
        .bubble       (bubble),
        .rs_q         (rs_q),
        .rt_q         (rt_q),
        .stage_addr   (stage_addr),
        .stage_we     (stage_we),
        .wb_addr      (wb_addr),
        .wb_we        (wb_we),
        .fwd_rs_hit   (fwd_rs_hit),
        .fwd_rs_stage (fwd_rs_stage),
        .fwd_rt_hit   (fwd_rt_hit),
        .fwd_rt_stage (fwd_rt_stage),
        .load_use     (load_use)
    );

    int n_total = 0;
    int n_pass  = 0;
    bit chk_on  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: the last DEPTH accepted instructions, youngest at index 0.
    int m_addr [DEPTH];
    bit m_we   [DEPTH];
    bit m_ld   [DEPTH];

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            m_addr[k] = 0; m_we[k] = 1'b0; m_ld[k] = 1'b0;
        end
    end

    always @(posedge clock) begin
        int a;
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_addr[k] = 0; m_we[k] = 1'b0; m_ld[k] = 1'b0;
            end
        end else if (!hold) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                m_addr[k] = m_addr[k-1]; m_we[k] = m_we[k-1]; m_ld[k] = m_ld[k-1];
            end
            if (bubble || reg_dst == 2'b11) begin
                m_addr[0] = 0; m_we[0] = 1'b0; m_ld[0] = 1'b0;
            end else begin
                a = (reg_dst == 2'b00) ? int'(rt) : (reg_dst == 2'b01) ? int'(rd) : LINK_REG;
                m_addr[0] = a;
                m_we[0]   = reg_write_in && (a != 0);
                m_ld[0]   = mem_read_in && reg_write_in && (a != 0);
            end
        end
    end

    logic [31:0] e_addr_vec, e_we_vec;
    int          e_rs_st, e_rt_st;
    bit          e_rs_hit, e_rt_hit, e_lu;

    always @(negedge clock) begin
        if (chk_on) begin
            e_addr_vec = '0;
            e_we_vec   = '0;
            e_rs_hit = 1'b0; e_rs_st = 0;
            e_rt_hit = 1'b0; e_rt_st = 0;
            for (int k = 0; k < DEPTH; k++) begin
                e_addr_vec = e_addr_vec | (32'(m_addr[k]) << (k * ADDR_W));
                e_we_vec   = e_we_vec | (32'(m_we[k]) << k);
                if (!e_rs_hit && m_we[k] && m_addr[k] == int'(rs_q) && rs_q != 0) begin
                    e_rs_hit = 1'b1; e_rs_st = k;
                end
                if (!e_rt_hit && m_we[k] && m_addr[k] == int'(rt_q) && rt_q != 0) begin
                    e_rt_hit = 1'b1; e_rt_st = k;
                end
            end
            e_lu = m_ld[0] && m_addr[0] != 0 &&
                   (m_addr[0] == int'(rs_q) || m_addr[0] == int'(rt_q));
            check("stage_addr",   32'(stage_addr),   e_addr_vec);
            check("stage_we",     32'(stage_we),     e_we_vec);
            check("wb_addr",      32'(wb_addr),      32'(m_addr[DEPTH-1]));
            check("wb_we",        32'(wb_we),        32'(m_we[DEPTH-1]));
            check("fwd_rs_hit",   32'(fwd_rs_hit),   32'(e_rs_hit));
            check("fwd_rs_stage", 32'(fwd_rs_stage), 32'(e_rs_st));
            check("fwd_rt_hit",   32'(fwd_rt_hit),   32'(e_rt_hit));
            check("fwd_rt_stage", 32'(fwd_rt_stage), 32'(e_rt_st));
            check("load_use",     32'(load_use),     32'(e_lu));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int t, input int d, input int sel, input bit wr, input bit mr);
        rt = ADDR_W'(t); rd = ADDR_W'(d); reg_dst = 2'(sel);
        reg_write_in = wr; mem_read_in = mr; hold = 1'b0; bubble = 1'b0;
    endtask

    task automatic bub();
        hold = 1'b0; bubble = 1'b1;
    endtask

    logic [DEPTH*ADDR_W-1:0] snap_addr;
    logic [DEPTH-1:0]        snap_we;

    initial begin
        reset_n = 1'b0; rt = '0; rd = '0; reg_dst = 2'b00; reg_write_in = 1'b0;
        mem_read_in = 1'b0; hold = 1'b0; bubble = 1'b0; rs_q = '0; rt_q = '0;
        tick();
        chk_on  = 1'b1;
        reset_n = 1'b1;
        check("rst_stage_we", 32'(stage_we), 32'd0);

        // Preload every stage with a load to r5, then reset under hold.
        drive(0, 5, 1, 1'b1, 1'b1);
        rs_q = 5'd5; rt_q = 5'd5;
        tick(); tick(); tick();
        check("pre_fwd_rs_hit", 32'(fwd_rs_hit), 32'd1);
        check("pre_load_use",   32'(load_use),   32'd1);
        reset_n = 1'b0; hold = 1'b1; bubble = 1'b1;
        tick();
        reset_n = 1'b1;
        check("rst_we",   32'(stage_we),   32'd0);
        check("rst_addr", 32'(stage_addr), 32'd0);
        check("rst_wbwe", 32'(wb_we),      32'd0);
        check("rst_lu",   32'(load_use),   32'd0);
        check("rst_hit",  32'(fwd_rs_hit), 32'd0);
        rs_q = '0; rt_q = '0;

        // Select rd, then link, then reserved; three-edge latency to WB.
        drive(8, 9, 1, 1'b1, 1'b0); tick(); bub(); tick(); tick();
        check("lat_wb_addr", 32'(wb_addr), 32'd9);
        check("lat_wb_we",   32'(wb_we),   32'd1);
        drive(8, 9, 2, 1'b1, 1'b0); tick(); bub(); tick(); tick();
        check("link_wb_addr", 32'(wb_addr), 32'd31);
        drive(8, 9, 3, 1'b1, 1'b0); tick();
        check("rsvd_we0",   32'(stage_we[0]),     32'd0);
        check("rsvd_addr0", 32'(stage_addr[4:0]), 32'd0);
        bub(); tick(); tick();
        check("rsvd_wb_we", 32'(wb_we), 32'd0);

        // $zero destination.
        drive(8, 0, 1, 1'b1, 1'b0); tick();
        check("zero_we0",    32'(stage_we[0]), 32'd0);
        check("zero_rs_hit", 32'(fwd_rs_hit),  32'd0);

        // Forwarding priority with r5 in stages 0 and 2.
        drive(0, 5, 1, 1'b1, 1'b0); tick();
        drive(0, 6, 1, 1'b1, 1'b0); tick();
        drive(0, 5, 1, 1'b1, 1'b0); rs_q = 5'd5; tick();
        check("fwd_hit",    32'(fwd_rs_hit),   32'd1);
        check("fwd_stage0", 32'(fwd_rs_stage), 32'd0);
        bub(); tick();
        check("fwd_stage1", 32'(fwd_rs_stage), 32'd1);
        tick();
        check("fwd_stage2", 32'(fwd_rs_stage), 32'd2);

        // Load-use on stage 0 only.
        rs_q = '0; rt_q = 5'd7;
        drive(7, 3, 0, 1'b1, 1'b1); tick();
        check("lu_on", 32'(load_use), 32'd1);
        bub(); tick();
        check("lu_off",   32'(load_use),        32'd0);
        check("lu_addr1", 32'(stage_addr[9:5]), 32'd7);
        rt_q = '0;

        // Hold dominates bubble.
        drive(0, 10, 1, 1'b1, 1'b0); tick();
        drive(0, 11, 1, 1'b1, 1'b0); tick();
        snap_addr = stage_addr; snap_we = stage_we;
        hold = 1'b1; bubble = 1'b1; tick(); tick();
        check("hold_addr", 32'(stage_addr), 32'(snap_addr));
        check("hold_we",   32'(stage_we),   32'(snap_we));
        hold = 1'b0; tick();
        check("rel_we0",   32'(stage_we[0]),     32'd0);
        check("rel_addr1", 32'(stage_addr[9:5]), 32'd11);

        // Random traffic, addresses biased low to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            reset_n      = ($urandom_range(0, 49) != 0);
            rt           = ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
            rd           = ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
            reg_dst      = 2'($urandom);
            reg_write_in = ($urandom_range(0, 3) != 0);
            mem_read_in  = ($urandom_range(0, 2) == 0);
            hold         = ($urandom_range(0, 9) == 0);
            bubble       = ($urandom_range(0, 6) == 0);
            rs_q         = ($urandom_range(0, 3) != 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
            rt_q         = ($urandom_range(0, 3) != 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
            tick();
        end

        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regdst_pipe.md
Name: regdst_pipe

Overview:
- Parametrised successor to the single-cycle RegDst multiplexer, for the pipelined datapath.
- Selects the register-file write address from rt, rd or the link register (JAL).
- Carries that address and its write/load flags through a DEPTH-stage shift pipeline (EX..WB).
- Generates forwarding-match and load-use hazard indications for the decode stage from the in-flight destinations.

Parameters:
- ADDR_W, 5: register address width.
- DEPTH, 3: number of pipeline stages tracked. Stage 0 = EX, stage DEPTH-1 = WB. Legal range 2..8.
- LINK_REG, 31: address written when reg_dst selects link.

Ports:
- clock, input, 1: rising-edge clock.
- reset_n, input, 1: synchronous, active-low reset.
- rt, input, ADDR_W: instruction rt field.
- rd, input, ADDR_W: instruction rd field.
- reg_dst, input, 2: destination select from Control. 00 = rt, 01 = rd, 10 = LINK_REG, 11 = reserved.
- reg_write_in, input, 1: instruction writes the register file.
- mem_read_in, input, 1: instruction is a load.
- hold, input, 1: freeze the whole pipeline.
- bubble, input, 1: insert a no-write entry at stage 0 (stall or flush).
- rs_q, input, ADDR_W: decode-stage rs query address.
- rt_q, input, ADDR_W: decode-stage rt query address.
- stage_addr, output, DEPTH*ADDR_W: per-stage destination address. Stage k occupies bits [k*ADDR_W +: ADDR_W].
- stage_we, output, DEPTH: per-stage write enable.
- wb_addr, output, ADDR_W: equals stage DEPTH-1 address.
- wb_we, output, 1: equals stage DEPTH-1 write enable.
- fwd_rs_hit, output, 1: rs_q matches an in-flight write.
- fwd_rs_stage, output, SEL_W: youngest matching stage for rs_q.
- fwd_rt_hit, output, 1: rt_q matches an in-flight write.
- fwd_rt_stage, output, SEL_W: youngest matching stage for rt_q.
- load_use, output, 1: load-use hazard on stage 0.
- SEL_W = max(1, clog2(DEPTH)).

Behaviour:
- Reset: on a rising edge with reset_n=0, every stage's addr, we and load bits clear to 0.
  - Consequently all outputs read 0 (hits 0, stage indices 0, load_use 0).
  - Reset overrides hold and bubble.
  - Asserting reset mid-stream discards all in-flight entries in one cycle.
- Destination select (combinational):
  - sel_addr = rt / rd / LINK_REG per reg_dst.
  - sel_we = reg_write_in AND reg_dst != 11 AND sel_addr != 0. Writes to $zero never propagate as writes.
  - sel_load = mem_read_in AND sel_we.
- Update priority per edge, highest first: reset > hold > bubble > normal.
  - hold=1: all stages keep their value, including while bubble=1.
  - bubble=1 (hold=0): stage 0 takes addr=0, we=0, load=0; stages 1..DEPTH-1 shift (stage k <= stage k-1).
  - normal: stage 0 <= {sel_addr, sel_we, sel_load}; stages shift.
  - A value presented at cycle n appears at wb_addr/wb_we after DEPTH edges with no hold.
- Forwarding (combinational from registered state only; no input-to-output path except rs_q/rt_q compares):
  - For query q: a hit exists where stage_we[k]=1 AND stage_addr[k]==q AND q!=0.
  - fwd_*_stage = the smallest such k (youngest instruction wins).
  - With no hit, hit=0 and stage=0.
- load_use = stage0.load AND stage0.addr != 0 AND (stage0.addr==rs_q OR stage0.addr==rt_q).
  - Loads in stage >= 1 never raise load_use.
- reg_dst=11 behaves exactly as a bubble at stage 0; no error flag.

Decomposition:
- Shared package regdst_pkg:
  - REGDST_RT=2'b00, REGDST_RD=2'b01, REGDST_LINK=2'b10, REGDST_RSVD=2'b11.
  - REG_ZERO=0.
  - Struct/typedef for a stage entry {addr, we, load}.
- One natural sub-module: regdst_match, a parametrised priority comparator taking the stage vectors and a query and returning {hit, stage}. It is instantiated twice (rs, rt).

Test Plan:
- Reset: reset_n=0 for 1 edge with stages preloaded -> all stage_we=0, wb_we=0, load_use=0, fwd hits 0.
- Select and latency (DEPTH=3): rt=8, rd=9, reg_dst=01, reg_write_in=1 at cycle 0 -> wb_addr=9, wb_we=1 at cycle 3. reg_dst=10 -> wb_addr=31. reg_dst=11 -> wb_we=0.
- Zero suppression: rd=0, reg_dst=01, reg_write_in=1 -> stage_we[0]=0; rs_q=0 -> fwd_rs_hit=0.
- Forward priority: stage0 addr=5 we=1, stage2 addr=5 we=1, rs_q=5 -> fwd_rs_hit=1, fwd_rs_stage=0. After stage 0 becomes a bubble -> fwd_rs_stage=1 or 2 per shift position.
- Load-use: lw with rt=7, reg_dst=00, mem_read_in=1 into stage0; rt_q=7 -> load_use=1. Next edge with bubble=1 -> load_use=0, stage_addr[1]=7.
- Hold vs bubble: hold=1 and bubble=1 for 2 edges -> all stage outputs unchanged. Release hold with bubble=1 -> stage_we[0]=0 and prior stage 0 moves to stage 1.
